// File: rtl/reset_pkg.sv
// Shared types and constant helpers for the reset sequencer.
package reset_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2,
        ASSERT  = 2'd3
    } seq_state_t;

    // Release spacing in clock cycles; never less than one so the counter always has a terminal value.
    function automatic int delay_cycles(input int freq, input int ms);
        int d;
        d = (freq / 1000) * ms;
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/reset_synchroniser.sv
// Reset synchroniser: asserts asynchronously, releases after the chain has flushed.
module reset_synchroniser #(
    parameter int Stages = 2
) (
    input  logic clk,
    input  logic rst,
    output logic rst_sync
);

    logic [Stages-1:0] chain;

    // Shift zeros in once rst drops; the last stage is the synchronised reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '1;
        end else begin
            chain <= {chain[Stages-2:0], 1'b0};
        end
    end

    assign rst_sync = chain[Stages-1];

endmodule

// File: rtl/reset_sequencer.sv
// Sequenced per-channel reset release after PLL lock, with ordered re-assertion on abort.
//
// state   | meaning
// HOLD    | all channels in reset, waiting for reset release, lock and no soft request
// RELEASE | releasing channels 0..N-1, one every D cycles
// RUN     | all channels released, opReady high
// ASSERT  | re-asserting released channels, highest first, one per cycle
module reset_sequencer
    import reset_pkg::*;
#(
    parameter int Clk_Frequency = 50_000_000,
    parameter int Delay_ms      = 10,
    parameter int N_Channels    = 4,
    parameter int Sync_Stages   = 2
) (
    input  logic                  ipClk,
    input  logic                  ipReset,
    input  logic                  ipLocked,
    input  logic                  ipSoftReset,
    output logic [N_Channels-1:0] opReset,
    output logic                  opReady
);

    localparam int D  = delay_cycles(Clk_Frequency, Delay_ms);
    localparam int CW = $clog2(D + 1);
    localparam int KW = $clog2(N_Channels + 1);

    localparam logic [CW-1:0]         CNT_LAST = CW'(D - 1);
    localparam logic [KW-1:0]         K_LAST   = KW'(N_Channels - 1);
    localparam logic [N_Channels-1:0] TOP_BIT  = N_Channels'(1) << (N_Channels - 1);

    logic                   rst_sync;
    logic [Sync_Stages-1:0] lock_chain;
    logic                   lock_sync;
    logic                   abort;
    seq_state_t             state;
    logic [CW-1:0]          cnt;
    logic [KW-1:0]          k;

    reset_synchroniser #(
        .Stages(Sync_Stages)
    ) u_rst_sync (
        .clk     (ipClk),
        .rst     (ipReset),
        .rst_sync(rst_sync)
    );

    // Lock synchroniser; cleared by reset so lock must be re-qualified after every reset.
    always_ff @(posedge ipClk or posedge ipReset) begin
        if (ipReset) begin
            lock_chain <= '0;
        end else begin
            lock_chain <= {lock_chain[Sync_Stages-2:0], ipLocked};
        end
    end

    assign lock_sync = lock_chain[Sync_Stages-1];
    // Soft request and lock loss collapse into one abort condition.
    assign abort     = ipSoftReset | ~lock_sync;

    // Sequencer FSM; channels shift out of reset from bit 0 and back in from the top bit,
    // so a channel can never be released while a lower one is held.
    always_ff @(posedge ipClk or posedge rst_sync) begin
        if (rst_sync) begin
            state   <= HOLD;
            cnt     <= '0;
            k       <= '0;
            opReset <= '1;
            opReady <= 1'b0;
        end else begin
            case (state)
                HOLD: begin
                    opReset <= '1;
                    opReady <= 1'b0;
                    cnt     <= '0;
                    k       <= '0;
                    if (lock_sync && !ipSoftReset) begin
                        state <= RELEASE;
                    end
                end
                RELEASE: begin
                    opReady <= 1'b0;
                    if (abort) begin
                        cnt   <= '0;
                        state <= (k == '0) ? HOLD : ASSERT;
                    end else if (cnt == CNT_LAST) begin
                        cnt     <= '0;
                        k       <= k + KW'(1);
                        opReset <= opReset << 1;
                        if (k == K_LAST) begin
                            state <= RUN;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RUN: begin
                    opReset <= '0;
                    if (abort) begin
                        opReady <= 1'b0;
                        state   <= ASSERT;
                    end else begin
                        opReady <= 1'b1;
                    end
                end
                ASSERT: begin
                    opReady <= 1'b0;
                    opReset <= (opReset >> 1) | TOP_BIT;
                    k       <= k - KW'(1);
                    if (k == KW'(1)) begin
                        state <= HOLD;
                    end
                end
                default: begin
                    state   <= HOLD;
                    opReset <= '1;
                    opReady <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 The block SHALL expose parameter Clk_Frequency, default 50_000_000, clock frequency in Hz.
REQ-002 The block SHALL expose parameter Delay_ms, default 10, release delay per channel in ms.
REQ-003 The block SHALL expose parameter N_Channels, default 4, number of sequenced reset outputs (1..16).
REQ-004 The block SHALL expose parameter Sync_Stages, default 2, synchroniser depth (minimum 2).
REQ-005 The block SHALL have port ipClk, input, 1, sole clock.
REQ-006 The block SHALL have port ipReset, input, 1, asynchronous active-high reset.
REQ-007 The block SHALL have port ipLocked, input, 1, asynchronous PLL-lock indication, high = locked.
REQ-008 The block SHALL have port ipSoftReset, input, 1, synchronous level request to re-enter reset.
REQ-009 The block SHALL have port opReset, output, N_Channels, active-high per-channel resets, channel 0 released first.
REQ-010 The block SHALL have port opReady, output, 1, high only when every channel is released.

Function
REQ-011 D SHALL equal max(1, (Clk_Frequency/1000)*Delay_ms) cycles, and the counter width SHALL be $clog2(D+1).
REQ-012 ipReset deassertion and ipLocked SHALL each pass through Sync_Stages flops before use; ipReset assertion SHALL bypass the synchroniser.
REQ-013 The FSM SHALL have exactly the states HOLD, RELEASE, RUN and ASSERT.
REQ-014 In HOLD, all opReset bits SHALL be 1 and opReady SHALL be 0.
REQ-015 HOLD SHALL transition to RELEASE on the first edge with synchronised reset low, synchronised lock high and ipSoftReset low; the counter SHALL be 0 and the channel index SHALL be 0 on entry.
REQ-016 In RELEASE, the counter SHALL increment each cycle; at count D-1, opReset[k] SHALL clear, the counter SHALL clear and k SHALL increment.
REQ-017 Channel k SHALL therefore clear exactly (k+1)*D cycles after RELEASE entry.
REQ-018 After channel N_Channels-1 clears, the FSM SHALL go to RUN, and opReady SHALL rise on the following edge.
REQ-019 RUN SHALL hold all opReset bits at 0 and opReady at 1.
REQ-020 In RUN or RELEASE, ipSoftReset high or synchronised lock low SHALL drop opReady the next edge and enter ASSERT.
REQ-021 ASSERT SHALL re-assert released channels in reverse order, highest first, one per cycle, then enter HOLD.
REQ-022 If RELEASE is aborted with no channel released, the FSM SHALL go directly to HOLD.
REQ-023 In ASSERT, further soft-reset or lock-loss events SHALL be ignored; the sequence SHALL complete.
REQ-024 If soft reset and lock loss are simultaneous, they SHALL be treated as one abort.
REQ-025 A channel SHALL never be released while any lower-numbered channel is asserted.
REQ-026 Lock returning in ASSERT or HOLD SHALL not shorten the sequence; release SHALL restart from channel 0 with a full D per channel.
REQ-027 A D value exceeding counter range SHALL be impossible by construction (REQ-011).

Reset
REQ-028 ipReset high SHALL immediately and asynchronously force opReset to all 1s, opReady to 0, the FSM to HOLD, and the counter and k to 0, from any state.
REQ-029 After ipReset falls, HOLD SHALL persist for at least Sync_Stages edges before RELEASE can be entered.

Structure
REQ-030 Package reset_pkg SHALL hold the state enum typedef and a delay_cycles(freq, ms) constant function implementing REQ-011.
REQ-031 Sub-module reset_synchroniser (async assert, Sync_Stages-deep synchronous release) SHALL be instantiated for ipReset; ipLocked SHALL use a plain Sync_Stages flop chain.
REQ-032 The block SHALL contain no latches or derived clocks, and all outputs SHALL be registered.

Verification
Use Clk_Frequency=10_000, Delay_ms=1, N_Channels=3, Sync_Stages=2, giving D=10.
REQ-033 Bench SHALL check: ipLocked=1 held, ipReset released at t0 -> RELEASE entered at edge t0+2; opReset 111->110 at +10, 100 at +20, 000 at +30; opReady=1 at +31.
REQ-034 Bench SHALL check: ipLocked=0 for 100 cycles after reset -> opReset stays 111 and opReady=0; lock rises -> release begins 2 edges later with full 10-cycle spacing.
REQ-035 Bench SHALL check: ipSoftReset pulse for 1 cycle in RUN -> opReady=0 next edge; opReset 000->100->110->111 on consecutive edges; re-release follows REQ-033 timing.
REQ-036 Bench SHALL check: ipLocked drops after channel 0 clears (opReset=110) -> one ASSERT cycle gives 111, then HOLD.
REQ-037 Bench SHALL check: ipReset pulsed asynchronously mid-RELEASE, between clock edges -> opReset=111 and opReady=0 before the next edge; counter restarts from 0.
REQ-038 Bench SHALL check: Delay_ms=0 -> D=1; channels clear on consecutive edges.
